instr_mem_loadable: RTL and testbench

//  Parametrised, writable successor to the fixed instruction ROM. Holds the program for the

---
 rtl/instr_mem_loadable.sv | 161 ++++++++++++++++
 tb/tb_instr_mem_loadable.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable
//   Writable instruction memory for the simple CPU. Synchronous RAM with a registered fetch
//   port toward the core and a write port that either streams a whole program from address 0
//   (LOAD) or patches single words (IDLE). After reset the RAM is swept to DEFAULT_WORD (CLEAR)
//   so the core never fetches undefined data.
//
// Ports
//   Clock         in   rising-edge clock
//   Reset         in   asynchronous, active-low reset
//   iAddress      in   16-bit fetch address from the core PC
//   iFetchEn      in   fetch request; low holds oInstruction/oValid (stall)
//   oInstruction  out  registered fetched word
//   oValid        out  oInstruction holds the result of an accepted fetch
//   iLoadStart    in   pulse: enter LOAD, write pointer restarts at 0
//   iWrValid      in   write strobe (LOAD: stream word, IDLE: random write)
//   iWrLast       in   marks final stream word in LOAD
//   iWrAddr       in   random-write address (IDLE only)
//   iWrData       in   write data
//   oBusy         out  high during CLEAR or LOAD; fetches ignored while high
//   oLoadCount    out  words written by the last completed LOAD
//   oOverflow     out  sticky: last LOAD hit the top of memory without iWrLast

module instr_mem_loadable #(
  parameter int unsigned       DATA_W       = 28,
  parameter int unsigned       ADDR_W       = 8,
  parameter logic [DATA_W-1:0] DEFAULT_WORD = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       iAddress,
  input  logic              iFetchEn,
  output logic [DATA_W-1:0] oInstruction,
  output logic              oValid,
  input  logic              iLoadStart,
  input  logic              iWrValid,
  input  logic              iWrLast,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  output logic              oBusy,
  output logic [ADDR_W:0]   oLoadCount,
  output logic              oOverflow
);

  localparam int unsigned     DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StClear, StIdle, StLoad} state_e;

  state_e              state_q;
  // One bit wider than the address so a full-memory count is representable.
  logic [ADDR_W:0]     ptr_q;
  logic [DATA_W-1:0]   instr_q;
  logic                valid_q;
  logic [ADDR_W:0]     count_q;
  logic                ovf_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                fetch_in_range;
  logic [ADDR_W-1:0]   fetch_addr;

  assign fetch_in_range = 32'(iAddress) < DEPTH;
  assign fetch_addr     = iAddress[ADDR_W-1:0];

  // Single RAM write port shared by the clear sweep, stream load and random patch.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = DEFAULT_WORD;
    case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q[ADDR_W-1:0];
      end
      StIdle: begin
        // A write coinciding with iLoadStart is dropped.
        if (iWrValid && !iLoadStart) begin
          mem_we    = 1'b1;
          mem_waddr = iWrAddr;
          mem_wdata = iWrData;
        end
      end
      StLoad: begin
        if (iWrValid) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q[ADDR_W-1:0];
          mem_wdata = iWrData;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StClear;
      ptr_q   <= '0;
      instr_q <= DEFAULT_WORD;
      valid_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StClear: begin
          if (ptr_q == LAST_PTR) begin
            ptr_q   <= '0;
            state_q <= StIdle;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        StIdle: begin
          // Fetch reads the RAM with non-blocking semantics: same-cycle write is read-first.
          if (iFetchEn) begin
            valid_q <= 1'b1;
            instr_q <= fetch_in_range ? mem[fetch_addr] : DEFAULT_WORD;
          end
          if (iLoadStart) begin
            state_q <= StLoad;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        StLoad: begin
          valid_q <= 1'b0;
          if (iWrValid) begin
            ptr_q <= ptr_q + 1'b1;
            if (iWrLast) begin
              count_q <= ptr_q + 1'b1;
              state_q <= StIdle;
            end else if (ptr_q == LAST_PTR) begin
              // Top of memory reached without a last marker: stop, never wrap.
              count_q <= FULL_CNT;
              ovf_q   <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign oInstruction = instr_q;
  assign oValid       = valid_q;
  assign oBusy        = (state_q != StIdle);
  assign oLoadCount   = count_q;
  assign oOverflow    = ovf_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
module tb_instr_mem_loadable;

  localparam int DATA_W = 28;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic [15:0]       iAddress = '0;
  logic              iFetchEn = 1'b0;
  logic [DATA_W-1:0] oInstruction;
  logic              oValid;
  logic              iLoadStart = 1'b0;
  logic              iWrValid = 1'b0;
  logic              iWrLast = 1'b0;
  logic [ADDR_W-1:0] iWrAddr = '0;
  logic [DATA_W-1:0] iWrData = '0;
  logic              oBusy;
  logic [ADDR_W:0]   oLoadCount;
  logic              oOverflow;

  instr_mem_loadable #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEFAULT_WORD(28'h0)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iAddress    (iAddress),
    .iFetchEn    (iFetchEn),
    .oInstruction(oInstruction),
    .oValid      (oValid),
    .iLoadStart  (iLoadStart),
    .iWrValid    (iWrValid),
    .iWrLast     (iWrLast),
    .iWrAddr     (iWrAddr),
    .iWrData     (iWrData),
    .oBusy       (oBusy),
    .oLoadCount  (oLoadCount),
    .oOverflow   (oOverflow)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural reference: program image plus the externally visible status.
  int unsigned ref_mem [DEPTH];
  int unsigned m_instr;
  bit          m_valid;
  int          m_clear_left;
  bit          m_loading;
  int          m_wr_cnt;
  int          m_count;
  bit          m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    foreach (ref_mem[i]) ref_mem[i] = 0;
    m_instr = 0; m_valid = 0; m_clear_left = DEPTH;
    m_loading = 0; m_wr_cnt = 0; m_count = 0; m_ovf = 0;
  endtask

  task automatic idle_inputs();
    iFetchEn = 0; iLoadStart = 0; iWrValid = 0; iWrLast = 0;
  endtask

  // Advance the model by one clock using current inputs, then clock the DUT.
  task automatic tick();
    if (m_clear_left > 0) begin
      m_clear_left--;
    end else if (m_loading) begin
      m_valid = 0;
      if (iWrValid) begin
        ref_mem[m_wr_cnt] = iWrData;
        m_wr_cnt++;
        if (iWrLast) begin
          m_loading = 0; m_count = m_wr_cnt;
        end else if (m_wr_cnt == DEPTH) begin
          m_loading = 0; m_count = DEPTH; m_ovf = 1;
        end
      end
    end else begin
      if (iFetchEn) begin
        m_valid = 1;
        m_instr = (int'(iAddress) < DEPTH) ? ref_mem[iAddress] : 0;
      end
      if (iLoadStart) begin
        m_loading = 1; m_wr_cnt = 0; m_ovf = 0;
      end else if (iWrValid) begin
        ref_mem[iWrAddr] = iWrData;
      end
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".instr"}, 32'(oInstruction), m_instr);
    check({tag, ".valid"}, 32'(oValid), 32'(m_valid));
    check({tag, ".busy"}, 32'(oBusy), 32'(m_clear_left > 0 || m_loading));
    check({tag, ".count"}, 32'(oLoadCount), m_count);
    check({tag, ".ovf"}, 32'(oOverflow), 32'(m_ovf));
  endtask

  // Counts busy cycles after reset release; bounded so a stuck DUT cannot hang the run.
  task automatic wait_clear(input string tag);
    int busy_cycles = 0;
    while (oBusy && busy_cycles < 1000) begin
      tick();
      busy_cycles++;
    end
    check({tag, ".busy_cycles"}, busy_cycles, DEPTH);
    check_all({tag, ".after_clear"});
  endtask

  task automatic fetch(input int a);
    iFetchEn = 1; iAddress = 16'(a);
    tick();
    iFetchEn = 0;
  endtask

  initial begin
    model_reset();
    idle_inputs();
    repeat (2) @(posedge Clock);
    #1;
    check_all("reset");
    Reset = 1;

    // 1: clear sweep, then fetch a cleared word
    wait_clear("t1");
    fetch(5);
    check("t1.fetch5", 32'(oInstruction), 32'h0);
    check("t1.valid", 32'(oValid), 1);

    // 2: short stream load and readback
    iLoadStart = 1; tick(); iLoadStart = 0;
    for (int i = 0; i < 8; i++) begin
      iWrValid = 1; iWrData = 28'h100_0000 + 28'(i); iWrLast = (i == 7);
      tick();
    end
    idle_inputs();
    check_all("t2.loaded");
    check("t2.count", 32'(oLoadCount), 8);
    iFetchEn = 1;
    for (int i = 0; i < 8; i++) begin
      iAddress = 16'(i);
      tick();
      check("t2.read", 32'(oInstruction), 32'h100_0000 + i);
      check_all("t2.read");
    end
    idle_inputs();

    // 3: out-of-range fetch, then stall
    fetch(300);
    check("t3.oor", 32'(oInstruction), 32'h0);
    check("t3.oor_valid", 32'(oValid), 1);
    for (int i = 0; i < 3; i++) begin
      iAddress = 16'(i + 1);
      tick();
      check("t3.hold_instr", 32'(oInstruction), 32'h0);
      check_all("t3.hold");
    end

    // 4: read-first on same-cycle write/fetch
    iWrValid = 1; iWrAddr = 3; iWrData = 28'hABCDEF0;
    fetch(3);
    iWrValid = 0;
    check("t4.old", 32'(oInstruction), 32'h100_0003);
    fetch(3);
    check("t4.new", 32'(oInstruction), 32'hABCDEF0);
    check_all("t4");

    // 5: full stream without last marker
    iLoadStart = 1; tick(); iLoadStart = 0;
    for (int i = 0; i < DEPTH; i++) begin
      iWrValid = 1; iWrData = 28'($urandom);
      tick();
    end
    idle_inputs();
    check("t5.ovf", 32'(oOverflow), 1);
    check("t5.count", 32'(oLoadCount), 256);
    check("t5.busy", 32'(oBusy), 0);
    fetch(0);
    check_all("t5.fetch0");

    // 6: reset in the middle of a load
    iLoadStart = 1; tick(); iLoadStart = 0;
    for (int i = 0; i < 4; i++) begin
      iWrValid = 1; iWrData = 28'h5A5_0000 + 28'(i);
      tick();
    end
    Reset = 0;
    model_reset();
    #1;
    check_all("t6.reset");
    idle_inputs();
    @(posedge Clock);
    #1;
    Reset = 1;
    wait_clear("t6");
    for (int i = 0; i < 4; i++) begin
      fetch(i);
      check("t6.cleared", 32'(oInstruction), 32'h0);
    end

    // Random mix of fetches, patches and loads
    for (int c = 0; c < 1500; c++) begin
      if (m_loading) begin
        iFetchEn = 1'($urandom); iAddress = 16'($urandom_range(0, 299));
        iLoadStart = 1'($urandom_range(0, 9) == 0);
        iWrValid = 1'($urandom); iWrLast = ($urandom_range(0, 15) == 0);
      end else begin
        iFetchEn = 1'($urandom); iAddress = 16'($urandom_range(0, 299));
        iLoadStart = ($urandom_range(0, 49) == 0);
        iWrValid = 1'($urandom); iWrLast = 1'($urandom);
        iWrAddr = 8'($urandom);
      end
      iWrData = 28'($urandom);
      tick();
      check_all("rand");
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
